// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate data cache between a CPU word port
// and a line-wide memory port. One outstanding CPU request at a time.
module cache #(
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned NUM_LINES      = 256,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_W-1:0]               cpu_req_addr,
  input  logic                            cpu_req_valid,
  input  logic                            cpu_req_wr,
  input  logic [31:0]                     cpu_wr_data,
  output logic [31:0]                     cpu_rd_data,
  output logic                            cpu_req_ready,
  output logic [ADDR_W-1:0]               mem_req_addr,
  output logic                            mem_req_valid,
  output logic                            mem_req_wr,
  output logic [32*WORDS_PER_LINE-1:0]    mem_wr_data,
  input  logic [32*WORDS_PER_LINE-1:0]    mem_rd_data,
  input  logic                            mem_req_ready
);

  localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
  localparam int unsigned OFFSET_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W   = 32 * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Latched CPU request
  logic [ADDR_W-1:0]   req_addr;
  logic                req_wr;
  logic [31:0]         req_wr_data;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;

  // Line storage
  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_bits;
  logic [NUM_LINES-1:0] dirty_bits;

  // Indexed line view and control strobes
  logic [LINE_W-1:0] line_data;
  logic [TAG_W-1:0]  line_tag;
  logic              line_valid;
  logic              line_dirty;
  logic              hit;
  logic [31:0]       hit_word;
  logic              mem_done;
  logic              accept;
  logic              hit_rd;
  logic              hit_wr;
  logic              fill;

  assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign req_index  = req_addr[OFFSET_W +: INDEX_W];
  assign req_offset = req_addr[OFFSET_W-1:0];

  assign line_data  = data_mem[req_index];
  assign line_tag   = tag_mem[req_index];
  assign line_valid = valid_bits[req_index];
  assign line_dirty = dirty_bits[req_index];
  assign hit        = line_valid && (line_tag == req_tag);
  assign hit_word   = line_data[{req_offset, 5'b0} +: 32];

  // A memory transfer completes only while our request is actually presented
  assign mem_done = mem_req_valid && mem_req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    hit_rd     = 1'b0;
    hit_wr     = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        // The completion pulse cycle is still IDLE; hold off a new request until it ends
        if (cpu_req_valid && !cpu_req_ready) begin
          accept     = 1'b1;
          next_state = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          hit_rd     = !req_wr;
          hit_wr     = req_wr;
          next_state = IDLE;
        end else if (line_valid && line_dirty) begin
          next_state = WRITE_BACK;
        end else begin
          next_state = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (mem_done) begin
          next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_done) begin
          fill       = 1'b1;
          next_state = COMPARE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request capture on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr    <= '0;
      req_wr      <= 1'b0;
      req_wr_data <= '0;
    end else if (accept) begin
      req_addr    <= cpu_req_addr;
      req_wr      <= cpu_req_wr;
      req_wr_data <= cpu_wr_data;
    end
  end

  // Valid/dirty bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill) begin
      valid_bits[req_index] <= 1'b1;
      dirty_bits[req_index] <= 1'b0;
    end else if (hit_wr) begin
      dirty_bits[req_index] <= 1'b1;
    end
  end

  // Line data and tag storage: refill installs a line, write hit merges one word
  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      data_mem[req_index] <= mem_rd_data;
      tag_mem[req_index]  <= req_tag;
    end else if (!rst && hit_wr) begin
      data_mem[req_index][{req_offset, 5'b0} +: 32] <= req_wr_data;
    end
  end

  // Registered CPU and memory port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_req_ready <= 1'b0;
      cpu_rd_data   <= '0;
      mem_req_valid <= 1'b0;
      mem_req_wr    <= 1'b0;
      mem_req_addr  <= '0;
      mem_wr_data   <= '0;
    end else begin
      cpu_req_ready <= hit_rd || hit_wr;
      if (hit_rd) begin
        cpu_rd_data <= hit_word;
      end
      // Valid drops for one cycle after every completed transfer, including write-back to fill
      mem_req_valid <= ((next_state == WRITE_BACK) || (next_state == ALLOCATE)) && !mem_done;
      if (next_state == WRITE_BACK) begin
        mem_req_wr   <= 1'b1;
        mem_req_addr <= {line_tag, req_index, {OFFSET_W{1'b0}}};
        mem_wr_data  <= line_data;
      end else if (next_state == ALLOCATE) begin
        mem_req_wr   <= 1'b0;
        mem_req_addr <= {req_tag, req_index, {OFFSET_W{1'b0}}};
      end else begin
        mem_req_wr   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for the direct-mapped write-back cache.
module tb_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [16:0]  cpu_req_addr;
  logic         cpu_req_valid;
  logic         cpu_req_wr;
  logic [31:0]  cpu_wr_data;
  logic [31:0]  cpu_rd_data;
  logic         cpu_req_ready;
  logic [16:0]  mem_req_addr;
  logic         mem_req_valid;
  logic         mem_req_wr;
  logic [127:0] mem_wr_data;
  logic [127:0] mem_rd_data;
  logic         mem_req_ready;

  always #5 clk = ~clk;

  cache dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_wr    (cpu_req_wr),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_rd_data   (cpu_rd_data),
    .cpu_req_ready (cpu_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_valid (mem_req_valid),
    .mem_req_wr    (mem_req_wr),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .mem_req_ready (mem_req_ready)
  );

  typedef struct {
    bit           wr;
    logic [16:0]  addr;
    logic [127:0] data;
  } xact_t;

  typedef struct {
    bit           hit;
    bit           wb;
    bit           fill;
    logic [16:0]  wb_addr;
    logic [127:0] wb_data;
    logic [16:0]  fill_addr;
    logic [31:0]  rdata;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  int wait_cnt = 0;

  // Memory device contents and its log of completed transfers
  logic [127:0] resp_mem [bit [14:0]];
  xact_t        xlog[$];

  // Per-cycle trace captured during an access
  bit          tr_valid[$];
  bit          tr_wr[$];
  bit          tr_mrdy[$];
  logic [16:0] tr_addr[$];

  // Reference model: flat line memory plus an abstract direct-mapped cache
  logic [127:0] exp_mem [bit [14:0]];
  bit           m_valid [256];
  bit           m_dirty [256];
  logic [6:0]   m_tag   [256];
  logic [127:0] m_data  [256];

  function automatic logic [127:0] init_line(input bit [14:0] l);
    logic [127:0] v;
    for (int w = 0; w < 4; w++) v[32*w +: 32] = (32'(l) * 32'h9E3779B1) ^ (32'(w) << 28);
    return v;
  endfunction

  function automatic logic [127:0] resp_line(input bit [14:0] l);
    if (resp_mem.exists(l)) return resp_mem[l];
    return init_line(l);
  endfunction

  function automatic logic [127:0] exp_line(input bit [14:0] l);
    if (exp_mem.exists(l)) return exp_mem[l];
    return init_line(l);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endfunction

  function automatic void model_access(input logic [16:0] addr, input bit wr,
                                       input logic [31:0] wdata, output exp_t e);
    int idx = int'(addr[9:2]);
    int off = int'(addr[1:0]);
    logic [6:0] tag = addr[16:10];
    e.hit  = m_valid[idx] && (m_tag[idx] == tag);
    e.wb   = 1'b0;
    e.fill = 1'b0;
    e.wb_addr = '0;
    e.wb_data = '0;
    e.fill_addr = '0;
    if (!e.hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        e.wb      = 1'b1;
        e.wb_addr = {m_tag[idx], 8'(idx), 2'b00};
        e.wb_data = m_data[idx];
        exp_mem[{m_tag[idx], 8'(idx)}] = m_data[idx];
      end
      e.fill      = 1'b1;
      e.fill_addr = {tag, 8'(idx), 2'b00};
      m_data[idx]  = exp_line({tag, 8'(idx)});
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_data[idx][32*off +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end
    e.rdata = m_data[idx][32*off +: 32];
  endfunction

  // Memory responder: answers after mem_lat waiting cycles, zero means same cycle
  always @(posedge clk) begin
    #1;
    if (rst || !mem_req_valid) begin
      mem_req_ready = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= mem_lat) begin
      mem_req_ready = 1'b1;
      mem_rd_data = resp_line(mem_req_addr[16:2]);
      xlog.push_back('{mem_req_wr, mem_req_addr, mem_wr_data});
      if (mem_req_wr) resp_mem[mem_req_addr[16:2]] = mem_wr_data;
    end else begin
      mem_req_ready = 1'b0;
      wait_cnt++;
    end
  end

  // One CPU access, started and finished at a falling edge with the cache idle
  task automatic do_access(input logic [16:0] addr, input bit wr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int lat, output bit timeout);
    xlog.delete();
    tr_valid.delete(); tr_wr.delete(); tr_mrdy.delete(); tr_addr.delete();
    rdata = '0;
    timeout = 1'b1;
    cpu_req_addr  = addr;
    cpu_req_wr    = wr;
    cpu_wr_data   = wdata;
    cpu_req_valid = 1'b1;
    @(negedge clk);
    lat = 1;
    // Inputs after acceptance are noise the cache must ignore
    cpu_req_valid = 1'($urandom_range(0, 1));
    cpu_req_addr  = 17'($urandom);
    cpu_req_wr    = 1'($urandom_range(0, 1));
    cpu_wr_data   = $urandom;
    while (lat < 300) begin
      tr_valid.push_back(mem_req_valid);
      tr_wr.push_back(mem_req_wr);
      tr_mrdy.push_back(mem_req_ready);
      tr_addr.push_back(mem_req_addr);
      if (cpu_req_ready) begin
        rdata = cpu_rd_data;
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
    cpu_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_wr = 1'b0; cpu_wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (cpu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got %0h exp 0", cpu_req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %0h exp 0", mem_req_valid); end
    checks++; if (mem_req_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %0h exp 0", mem_req_wr); end
    checks++; if (cpu_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", cpu_rd_data); end
    checks++; if (mem_req_addr !== 17'h0) begin errors++; $display("FAIL reset_mem_addr got %0h exp 0", mem_req_addr); end
    checks++; if (mem_wr_data !== 128'h0) begin errors++; $display("FAIL reset_mem_wr_data got %0h exp 0", mem_wr_data); end
  endtask

  task automatic test_read_miss();
    exp_t e; logic [31:0] rd; int lat; bit to;
    model_access(17'h0FADE, 1'b0, 32'h0, e);
    do_access(17'h0FADE, 1'b0, 32'h0, rd, lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rdmiss_timeout got %0d exp 0", to); end
    checks++; if (xlog.size() != 1) begin errors++; $display("FAIL rdmiss_xacts got %0d exp 1", xlog.size()); end
    if (xlog.size() >= 1) begin
      checks++; if (xlog[0].wr !== 1'b0 || xlog[0].addr !== 17'h0FADC) begin errors++;
        $display("FAIL rdmiss_fill got wr=%0d addr=%0h exp wr=0 addr=0fadc", xlog[0].wr, xlog[0].addr); end
    end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rdmiss_data got %0h exp deadbeef", rd); end
  endtask

  task automatic test_write_miss();
    exp_t e; logic [31:0] rd; int lat; bit to;
    model_access(17'h0DAFE, 1'b1, 32'hFEEDDEAD, e);
    do_access(17'h0DAFE, 1'b1, 32'hFEEDDEAD, rd, lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL wrmiss_timeout got %0d exp 0", to); end
    checks++; if (xlog.size() != 1) begin errors++; $display("FAIL wrmiss_xacts got %0d exp 1", xlog.size()); end
    if (xlog.size() >= 1) begin
      checks++; if (xlog[0].wr !== 1'b0 || xlog[0].addr !== 17'h0DAFC) begin errors++;
        $display("FAIL wrmiss_fill got wr=%0d addr=%0h exp wr=0 addr=0dafc", xlog[0].wr, xlog[0].addr); end
    end
  endtask

  task automatic test_read_hit();
    exp_t e; logic [31:0] rd; int lat; bit to; bit any_valid;
    model_access(17'h0DAFE, 1'b0, 32'h0, e);
    do_access(17'h0DAFE, 1'b0, 32'h0, rd, lat, to);
    any_valid = 1'b0;
    foreach (tr_valid[i]) if (tr_valid[i]) any_valid = 1'b1;
    checks++; if (lat != 2) begin errors++; $display("FAIL rdhit_latency got %0d exp 2", lat); end
    checks++; if (any_valid !== 1'b0) begin errors++; $display("FAIL rdhit_mem_valid got %0d exp 0", any_valid); end
    checks++; if (xlog.size() != 0) begin errors++; $display("FAIL rdhit_xacts got %0d exp 0", xlog.size()); end
    checks++; if (rd !== 32'hFEEDDEAD) begin errors++; $display("FAIL rdhit_data got %0h exp feeddead", rd); end
  endtask

  task automatic test_evict();
    exp_t e; logic [31:0] rd; int lat; bit to;
    model_access(17'h0DEFE, 1'b0, 32'h0, e);
    do_access(17'h0DEFE, 1'b0, 32'h0, rd, lat, to);
    checks++; if (xlog.size() != 2) begin errors++; $display("FAIL evict_xacts got %0d exp 2", xlog.size()); end
    if (xlog.size() == 2) begin
      checks++; if (xlog[0].wr !== 1'b1 || xlog[0].addr !== 17'h0DAFC) begin errors++;
        $display("FAIL evict_wb got wr=%0d addr=%0h exp wr=1 addr=0dafc", xlog[0].wr, xlog[0].addr); end
      checks++; if (xlog[0].data !== {32'hDEADBEEF, 32'hFEEDDEAD, 32'hDEADBEEF, 32'hDEADBEEF}) begin errors++;
        $display("FAIL evict_wb_data got %0h exp deadbeeffeeddeaddeadbeefdeadbeef", xlog[0].data); end
      checks++; if (xlog[1].wr !== 1'b0 || xlog[1].addr !== 17'h0DEFC) begin errors++;
        $display("FAIL evict_fill got wr=%0d addr=%0h exp wr=0 addr=0defc", xlog[1].wr, xlog[1].addr); end
    end
    checks++; if (to !== 1'b0 || rd !== e.rdata) begin errors++; $display("FAIL evict_data got %0h exp %0h", rd, e.rdata); end
  endtask

  task automatic test_stall();
    exp_t e; logic [31:0] rd; int lat; bit to; int nvalid; int hs_lat; bit addr_bad;
    mem_lat = 5;
    model_access(17'h05554, 1'b0, 32'h0, e);
    do_access(17'h05554, 1'b0, 32'h0, rd, lat, to);
    mem_lat = 0;
    nvalid = 0; hs_lat = -1; addr_bad = 1'b0;
    foreach (tr_valid[i]) begin
      if (tr_valid[i]) begin
        nvalid++;
        if (tr_addr[i] !== 17'h05554 || tr_wr[i] !== 1'b0) addr_bad = 1'b1;
        if (tr_mrdy[i] && hs_lat < 0) hs_lat = i + 1;
      end
    end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout got %0d exp 0", to); end
    checks++; if (nvalid != 6) begin errors++; $display("FAIL stall_valid_cycles got %0d exp 6", nvalid); end
    checks++; if (addr_bad !== 1'b0) begin errors++; $display("FAIL stall_addr_stable got %0d exp 0", addr_bad); end
    checks++; if (hs_lat < 0 || lat != hs_lat + 2) begin errors++; $display("FAIL stall_ready_cycle got %0d exp %0d", lat, hs_lat + 2); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL stall_data got %0h exp %0h", rd, e.rdata); end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [31:0] rd; int lat; bit to; bit found; bit saw_ready;
    model_access(17'h0DEFE, 1'b1, 32'h12345678, e);
    do_access(17'h0DEFE, 1'b1, 32'h12345678, rd, lat, to);
    checks++; if (to !== 1'b0 || xlog.size() != 0) begin errors++; $display("FAIL rstmid_prep got to=%0d xacts=%0d exp 0 0", to, xlog.size()); end
    mem_lat = 20;
    cpu_req_addr = 17'h0DAFE; cpu_req_wr = 1'b0; cpu_req_valid = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req_valid && mem_req_wr) found = 1'b1;
      else @(negedge clk);
    end
    checks++; if (found !== 1'b1 || mem_req_addr !== 17'h0DEFC) begin errors++;
      $display("FAIL rstmid_wb_seen got found=%0d addr=%0h exp 1 0defc", found, mem_req_addr); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_mem_valid got %0h exp 0", mem_req_valid); end
    checks++; if (cpu_req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_cpu_ready got %0h exp 0", cpu_req_ready); end
    rst = 1'b0;
    model_reset();
    mem_lat = 0;
    saw_ready = 1'b0;
    repeat (3) begin @(negedge clk); if (cpu_req_ready || mem_req_valid) saw_ready = 1'b1; end
    checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got %0d exp 0", saw_ready); end
    model_access(17'h0DAFE, 1'b0, 32'h0, e);
    do_access(17'h0DAFE, 1'b0, 32'h0, rd, lat, to);
    checks++; if (xlog.size() != 1) begin errors++; $display("FAIL rstmid_xacts got %0d exp 1", xlog.size()); end
    if (xlog.size() >= 1) begin
      checks++; if (xlog[0].wr !== 1'b0 || xlog[0].addr !== 17'h0DAFC) begin errors++;
        $display("FAIL rstmid_fill got wr=%0d addr=%0h exp wr=0 addr=0dafc", xlog[0].wr, xlog[0].addr); end
    end
    checks++; if (rd !== 32'hFEEDDEAD) begin errors++; $display("FAIL rstmid_data got %0h exp feeddead", rd); end
    model_access(17'h0DEFE, 1'b0, 32'h0, e);
    do_access(17'h0DEFE, 1'b0, 32'h0, rd, lat, to);
    checks++; if (xlog.size() != 1 || rd !== e.rdata) begin errors++;
      $display("FAIL rstmid_lost_write got xacts=%0d data=%0h exp 1 %0h", xlog.size(), rd, e.rdata); end
  endtask

  task automatic test_back_to_back();
    exp_t ea, eb; logic [31:0] rd, rda, rdb; int lat; bit to; int n, first, second;
    model_access(17'h0FADE, 1'b0, 32'h0, ea);
    do_access(17'h0FADE, 1'b0, 32'h0, rd, lat, to);
    model_access(17'h0FADE, 1'b0, 32'h0, ea);
    model_access(17'h0FADC, 1'b0, 32'h0, eb);
    cpu_req_addr = 17'h0FADE; cpu_req_wr = 1'b0; cpu_req_valid = 1'b1;
    n = 0; first = -1; second = -1; rda = '0; rdb = '0;
    while (n < 20 && second < 0) begin
      @(negedge clk);
      n++;
      if (cpu_req_ready) begin
        if (first < 0) begin
          first = n; rda = cpu_rd_data; cpu_req_addr = 17'h0FADC;
        end else begin
          second = n; rdb = cpu_rd_data; cpu_req_valid = 1'b0;
        end
      end
    end
    cpu_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (first != 2) begin errors++; $display("FAIL b2b_first_cycle got %0d exp 2", first); end
    checks++; if (second != 5) begin errors++; $display("FAIL b2b_second_cycle got %0d exp 5", second); end
    checks++; if (rda !== ea.rdata) begin errors++; $display("FAIL b2b_first_data got %0h exp %0h", rda, ea.rdata); end
    checks++; if (rdb !== eb.rdata) begin errors++; $display("FAIL b2b_second_data got %0h exp %0h", rdb, eb.rdata); end
  endtask

  task automatic test_random();
    exp_t e; logic [31:0] rd; int lat; bit to;
    logic [7:0] idx_set [4];
    logic [6:0] tag_set [3];
    logic [16:0] addr; bit wr; logic [31:0] wd; int nexp; int fi;
    idx_set[0] = 8'h10; idx_set[1] = 8'h11; idx_set[2] = 8'hBF; idx_set[3] = 8'h55;
    tag_set[0] = 7'h01; tag_set[1] = 7'h02; tag_set[2] = 7'h37;
    for (int k = 0; k < 150; k++) begin
      addr = {tag_set[$urandom_range(0, 2)], idx_set[$urandom_range(0, 3)], 2'($urandom_range(0, 3))};
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      mem_lat = $urandom_range(0, 3);
      model_access(addr, wr, wd, e);
      do_access(addr, wr, wd, rd, lat, to);
      nexp = int'(e.wb) + int'(e.fill);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd_timeout iter %0d got %0d exp 0", k, to); end
      checks++; if (xlog.size() != nexp) begin errors++; $display("FAIL rnd_xacts iter %0d got %0d exp %0d", k, xlog.size(), nexp); end
      if (xlog.size() == nexp && e.wb) begin
        checks++; if (xlog[0].wr !== 1'b1 || xlog[0].addr !== e.wb_addr || xlog[0].data !== e.wb_data) begin errors++;
          $display("FAIL rnd_wb iter %0d got addr=%0h data=%0h exp addr=%0h data=%0h", k, xlog[0].addr, xlog[0].data, e.wb_addr, e.wb_data); end
      end
      if (xlog.size() == nexp && e.fill) begin
        fi = int'(e.wb);
        checks++; if (xlog[fi].wr !== 1'b0 || xlog[fi].addr !== e.fill_addr) begin errors++;
          $display("FAIL rnd_fill iter %0d got wr=%0d addr=%0h exp wr=0 addr=%0h", k, xlog[fi].wr, xlog[fi].addr, e.fill_addr); end
      end
      if (e.hit) begin
        checks++; if (lat != 2) begin errors++; $display("FAIL rnd_hit_latency iter %0d got %0d exp 2", k, lat); end
      end
      if (!wr) begin
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL rnd_data iter %0d got %0h exp %0h", k, rd, e.rdata); end
      end
    end
    mem_lat = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_req_ready = 1'b0;
    mem_rd_data   = '0;
    resp_mem[15'(17'h0FADC >> 2)] = {4{32'hDEADBEEF}};
    resp_mem[15'(17'h0DAFC >> 2)] = {4{32'hDEADBEEF}};
    exp_mem[15'(17'h0FADC >> 2)]  = {4{32'hDEADBEEF}};
    exp_mem[15'(17'h0DAFC >> 2)]  = {4{32'hDEADBEEF}};
    test_reset();
    test_read_miss();
    test_write_miss();
    test_read_hit();
    test_evict();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache.md
Name: cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and a 128-bit line-wide memory port.
- Serves 32-bit word reads and writes from the CPU.
- On a miss, evicts the dirty victim line to memory, refills the line, then completes the access.

Parameters:
- ADDR_W, 17: word-address width on both the CPU and memory ports.
- NUM_LINES, 256: number of lines (power of 2); INDEX_W = log2(NUM_LINES) = 8.
- WORDS_PER_LINE, 4: 32-bit words per line; line width 128 bits; OFFSET_W = 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req_addr  in  17  word address: [1:0] offset, [9:2] index, [16:10] tag.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_wr  in  1  1 = write, 0 = read.
- cpu_wr_data  in  32  store data.
- cpu_rd_data  out  32  load data; valid while cpu_req_ready = 1.
- cpu_req_ready  out  1  one-cycle completion pulse.
- mem_req_addr  out  17  line-aligned word address; [1:0] = 0.
- mem_req_valid  out  1  memory request active.
- mem_req_wr  out  1  1 = line write-back, 0 = line fill.
- mem_wr_data  out  128  victim line; word0 in [31:0].
- mem_rd_data  in  128  fill line; word0 in [31:0].
- mem_req_ready  in  1  memory completes the current request this cycle; mem_rd_data is valid in the same cycle.

Behaviour:
- Storage per line:
  - valid bit, dirty bit, 7-bit tag, 128-bit data.
  - Registers or inferred RAM; combinational read of the indexed line.
- Reset:
  - All valid and dirty bits cleared; state = IDLE.
  - cpu_req_ready, mem_req_valid and mem_req_wr = 0.
  - cpu_rd_data, mem_req_addr and mem_wr_data = 0.
  - Reset asserted mid-operation aborts immediately: back to IDLE, no completion pulse, line contents unspecified but marked invalid.
- FSM states: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- IDLE:
  - When cpu_req_valid = 1, latch addr, wr and wr_data, then go to COMPARE.
  - CPU inputs are ignored in all other states.
- COMPARE, hit (valid and tag match):
  - Read: cpu_rd_data = word[offset], cpu_req_ready = 1 for exactly one cycle, go to IDLE.
  - Write: replace word[offset], set dirty, pulse cpu_req_ready, go to IDLE.
  - Hit latency: 2 cycles from request acceptance to the ready pulse.
- COMPARE, miss:
  - If the line is valid and dirty, go to WRITE_BACK; otherwise go to ALLOCATE.
- WRITE_BACK:
  - mem_req_valid = 1, mem_req_wr = 1.
  - mem_req_addr = {old_tag, index, 2'b00}; mem_wr_data = stored line.
  - Hold these until mem_req_ready = 1, then go to ALLOCATE.
- ALLOCATE:
  - mem_req_valid = 1, mem_req_wr = 0, mem_req_addr = {req_tag, index, 2'b00}.
  - When mem_req_ready = 1, install mem_rd_data, set valid = 1, dirty = 0, tag = req_tag, then return to COMPARE; the access now hits.
- Memory outputs:
  - mem_req_valid deasserts in the cycle after mem_req_ready.
  - mem_req_valid = 0 in IDLE and COMPARE.
- mem_req_ready = 1 in the same cycle that mem_req_valid rises completes that request with no wait.
- One outstanding CPU request at a time.
- The CPU may drop cpu_req_valid after acceptance; the latched request is still completed.
- A new request is accepted in the cycle after the ready pulse at the earliest.
- Write miss: the whole line is allocated first, then the store word merges on the COMPARE hit.

Test Plan:
- After reset, read 17'h0FADE, mem_rd_data = {4{32'hDEADBEEF}}, mem_req_ready = 1:
  - Fill request: valid = 1, wr = 0, addr = 17'h0FADC.
  - Then cpu_req_ready pulse with cpu_rd_data = 32'hDEADBEEF.
  - No write-back is issued.
- Write 17'h0DAFE data 32'hFEEDDEAD (miss, clean line):
  - Fill at 17'h0DAFC, then cpu_req_ready pulse.
  - Line index 8'hBF becomes dirty.
- Read 17'h0DAFE:
  - No memory request (mem_req_valid stays 0).
  - cpu_rd_data = 32'hFEEDDEAD two cycles after acceptance.
- Read 17'h0DEFE (same index 8'hBF, tag 7'h37):
  - Write-back first: addr 17'h0DAFC, mem_wr_data[95:64] = 32'hFEEDDEAD, other words 32'hDEADBEEF.
  - Then fill at 17'h0DEFC, then the read completes.
- mem_req_ready held low for 5 cycles during ALLOCATE:
  - mem_req_valid and mem_req_addr stay stable throughout.
  - No cpu_req_ready until the cycle after ready arrives and the COMPARE hit completes.
- rst asserted during WRITE_BACK:
  - Next cycle: state IDLE, mem_req_valid = 0, no completion pulse.
  - A subsequent read of the same address misses and issues a fill only.
